draw_text_grid: RTL and testbench
=================================

# draw_text_grid

Parametrised text-overlay stage for the VGA pipeline. It draws a COLS×ROWS grid of 8×16 glyphs, each pixel replicated 2^SCALE times in x and y, at a fixed screen position. Glyph codes come from an external synchronous character RAM and pixel rows from an external synchronous font ROM. Over the single-colour rectangle text stage it adds programmable foreground and background colours, an opaque/transparent background mode, frame-based blinking and a blinking block cursor. It sits between any two vga_if stages and delays all timing signals by a fixed latency.

## Interface
Parameters:
- TEXT_POS_X, 128: left edge of the grid, in pixels.
- TEXT_POS_Y, 128: top edge of the grid, in pixels.
- COLS, 32: characters per row; must be a power of 2.
- ROWS, 8: character rows; must be a power of 2.
- SCALE, 2: log2 of the pixel replication factor.
- BLINK_FRAMES, 30: number of frames per blink half-period.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; synchronous, active-high.
- in  vga_if.in  -  upstream timing and rgb.
- out  vga_if.out  -  downstream timing and rgb.
- char_addr  out  $clog2(COLS*ROWS)  character RAM address, computed as row*COLS+col.
- char_code  in  8  character RAM data; valid 1 clk after char_addr.
- font_addr  out  11  font ROM address, {char_code[6:0], glyph_line[3:0]}.
- font_pixels  in  8  font ROM data; valid 1 clk after font_addr; bit 7 is the leftmost pixel.
- fg_rgb  in  12  glyph colour.
- bg_rgb  in  12  background colour inside the grid.
- opaque  in  1  1: bg_rgb fills non-glyph pixels; 0: upstream rgb passes through.
- blink_en  in  1  glyph pixels are hidden while the blink phase is off.
- cursor_en  in  1  enables the cursor.
- cursor_col  in  $clog2(COLS)  cursor column.
- cursor_row  in  $clog2(ROWS)  cursor row.

## Operation
- Grid area: x from TEXT_POS_X to TEXT_POS_X+(COLS*8<<SCALE)-1; y from TEXT_POS_Y to TEXT_POS_Y+(ROWS*16<<SCALE)-1.
- Relative coordinates: dx = hcount-TEXT_POS_X, dy = vcount-TEXT_POS_Y.
- col = dx>>(3+SCALE); row = dy>>(4+SCALE); glyph_line = (dy>>SCALE)[3:0]; bit_idx = 7-(dx>>SCALE)[2:0].
- Every relative coordinate and in_area flag is computed once at input and carried through the pipeline. No subtraction is repeated downstream.
- Pixel selection, in priority order:
  1. Blanking (hblnk or vblnk): rgb = 0.
  2. Outside the grid: rgb = upstream rgb, delayed.
  3. Cursor cell (cursor_en, cell matches cursor_col/row, phase on): colours are swapped. Glyph pixels use bg_rgb; all other pixels use fg_rgb.
  4. Glyph pixel set and (!blink_en or phase on): fg_rgb.
  5. Otherwise: bg_rgb if opaque, else upstream rgb.
- Blink timer:
  - Detects the rising edge of in.vblnk.
  - frame_cnt counts 0..BLINK_FRAMES-1 and wraps to 0.
  - phase toggles on each wrap.
- Control inputs (fg/bg/opaque/blink/cursor) are sampled at the pipeline stage that uses them. Changing them mid-frame takes effect on the next pixel; no glitch protection is provided.
- Any cursor_col/row value is legal; it matches only its own cell.

## Timing
- Latency from in to out is 4 clk for all of hcount, vcount, hsync, vsync, hblnk, vblnk and rgb.
- Pipeline stages:
  - Edge 1: char_addr registered.
  - Edge 2: char_code valid; font_addr registered.
  - Edge 3: font_pixels valid.
  - Edge 4: out registered.
- Reset values:
  - All out fields 0; char_addr and font_addr 0.
  - frame_cnt 0; phase = 1 (visible); vblnk edge detector 0.
- Reset mid-frame: outputs are 0 on the next edge. After reset releases, the first valid out appears 4 clk after the first input sampled.
- Blink: phase toggles on the vblnk rising edge that ends frame BLINK_FRAMES-1. A half-period is exactly BLINK_FRAMES frames.
- A vblnk rise coincident with reset is ignored.

## Structure
- Package text_pkg holds:
  - Constants CHAR_W=8, CHAR_H=16, TEXT_LATENCY=4.
  - The font_addr width.
  - typedef pixel_sel_t (BLANK, PASS, FG, BG).
- Sub-module text_blink_timer (clk, rst, vblnk, phase) contains the vblnk edge detector, frame_cnt and phase.
- Top level contains the 4-stage delay line, address generation and the pixel-select mux.

## Test plan
- Glyph render. COLS=32, SCALE=2, char RAM model returns 8'h41 at address 0, font model row 0 = 8'h80, opaque=0. Expect out.rgb = fg_rgb for hcount 128..131, vcount 128..131. Expect pass-through at hcount 132. Check 4-clk latency.
- Opaque mode. Set opaque=1, bg_rgb=12'h00f. Expect all non-glyph grid pixels = 12'h00f. Expect pixels outside the grid, e.g. x=127 and x=128+1024, to equal the upstream rgb.
- Addressing. At pixel (128+5*32, 128+3*64), expect char_addr = 3*32+5 = 101. With glyph_line=0 and char_code=8'h41, expect font_addr = {7'h41, 4'h0}.
- Blink. BLINK_FRAMES=2, blink_en=1. Expect glyphs visible in frames 0–1, hidden in frames 2–3, visible again in frame 4.
- Cursor. cursor_en=1 at (2,1), phase on. Expect cell (2,1) to show swapped colours. Expect cell (3,1) to render normally.
- Reset. Assert rst mid-line. Expect out fields 0, phase=1, frame_cnt=0. Expect the correct image on the next frame.

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg: shared constants and types for the text overlay stage
package text_pkg;
    localparam int CHAR_W       = 8;
    localparam int CHAR_H       = 16;
    localparam int TEXT_LATENCY = 4;
    localparam int FONT_AW      = 11;
    localparam int VGA_CW       = 11;
    typedef enum logic [1:0] {BLANK, PASS, FG, BG} pixel_sel_t;
    typedef struct packed {
        logic [VGA_CW-1:0] hcount;
        logic [VGA_CW-1:0] vcount;
        logic              hsync;
        logic              vsync;
        logic              hblnk;
        logic              vblnk;
        logic [11:0]       rgb;
    } vga_t;
endpackage

// File: rtl/vga_if.sv
// vga_if: timing and colour bundle passed between VGA pipeline stages
interface vga_if;
    import text_pkg::*;
    logic [VGA_CW-1:0] hcount;
    logic [VGA_CW-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [11:0]       rgb;
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/text_blink_timer.sv
// text_blink_timer: counts frames on vblnk rising edges and toggles the blink phase every BLINK_FRAMES frames
module text_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic vblnk,
    output logic phase
);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic          vblnk_q;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;
    logic          rise, wrap;

    always_comb begin
        rise        = vblnk && !vblnk_q;
        wrap        = rise && frame_cnt_q == FW'(BLINK_FRAMES - 1);
        frame_cnt_d = wrap ? '0 : rise ? frame_cnt_q + FW'(1) : frame_cnt_q;
        phase_d     = phase_q ^ wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q     <= 1'b0;
            frame_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            vblnk_q     <= vblnk;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase = phase_q;
endmodule

// File: rtl/draw_text_grid.sv
// draw_text_grid: 4-stage text overlay with colours, opaque mode, blinking and a block cursor
module draw_text_grid
    import text_pkg::*;
#(
    parameter int TEXT_POS_X   = 128,
    parameter int TEXT_POS_Y   = 128,
    parameter int COLS         = 32,
    parameter int ROWS         = 8,
    parameter int SCALE        = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        rst,
    vga_if.in                           in,
    vga_if.out                          out,
    output logic [$clog2(COLS*ROWS)-1:0] char_addr,
    input  logic [7:0]                  char_code,
    output logic [FONT_AW-1:0]          font_addr,
    input  logic [7:0]                  font_pixels,
    input  logic [11:0]                 fg_rgb,
    input  logic [11:0]                 bg_rgb,
    input  logic                        opaque,
    input  logic                        blink_en,
    input  logic                        cursor_en,
    input  logic [$clog2(COLS)-1:0]     cursor_col,
    input  logic [$clog2(ROWS)-1:0]     cursor_row
);
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);
    localparam int GRID_W = (COLS * CHAR_W) << SCALE;
    localparam int GRID_H = (ROWS * CHAR_H) << SCALE;

    typedef struct packed {
        vga_t          v;
        logic          in_area;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [3:0]    line;
        logic [2:0]    bit_idx;
    } stage_t;

    stage_t            s0, s1_q, s2_q, s3_q;
    vga_t              out_d, out_q;
    logic [VGA_CW-1:0] dx, dy;
    logic              phase, glyph, cursor_hit, unused_ok;
    pixel_sel_t        sel;

    always_comb begin
        dx         = in.hcount - VGA_CW'(TEXT_POS_X);
        dy         = in.vcount - VGA_CW'(TEXT_POS_Y);
        s0.v       = '{in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
        s0.in_area = int'(in.hcount) >= TEXT_POS_X && int'(in.hcount) < TEXT_POS_X + GRID_W &&
                     int'(in.vcount) >= TEXT_POS_Y && int'(in.vcount) < TEXT_POS_Y + GRID_H;
        s0.col     = CW'(dx >> (3 + SCALE));
        s0.row     = RW'(dy >> (4 + SCALE));
        s0.line    = 4'(dy >> SCALE);
        s0.bit_idx = ~3'(dx >> SCALE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            out_q <= '0;
        end else begin
            s1_q  <= s0;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            out_q <= out_d;
        end
    end

    // The RAM and ROM each register their address, so each lookup costs exactly one stage.
    assign char_addr = {s1_q.row, s1_q.col};
    assign font_addr = rst ? '0 : {char_code[6:0], s2_q.line};
    assign unused_ok = ^{char_code[7], dx, dy};

    text_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk   (clk),
        .rst   (rst),
        .vblnk (in.vblnk),
        .phase (phase)
    );

    always_comb begin
        glyph      = font_pixels[s3_q.bit_idx];
        cursor_hit = cursor_en && phase && s3_q.col == cursor_col && s3_q.row == cursor_row;
        sel        = (s3_q.v.hblnk || s3_q.v.vblnk) ? BLANK
                   : !s3_q.in_area ? PASS
                   : cursor_hit ? (glyph ? BG : FG)
                   : (glyph && (!blink_en || phase)) ? FG
                   : opaque ? BG : PASS;
        out_d      = s3_q.v;
        out_d.rgb  = sel == FG ? fg_rgb : sel == BG ? bg_rgb : sel == PASS ? s3_q.v.rgb : 12'h000;
    end

    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;
endmodule

// File: tb/tb_draw_text_grid.sv
// tb_draw_text_grid: directed checks of rendering, addressing, cursor, blink and reset
module tb_draw_text_grid;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_addr, char_code, font_pixels;
    logic [10:0] font_addr;
    logic [11:0] fg_rgb, bg_rgb;
    logic        opaque, blink_en, cursor_en;
    logic [4:0]  cursor_col;
    logic [2:0]  cursor_row;
    logic [7:0]  char_ram [256];
    logic [7:0]  font_rom [2048];
    int          n_cmp = 0;
    int          n_bad = 0;

    vga_if vin();
    vga_if vout();

    draw_text_grid #(
        .TEXT_POS_X(128), .TEXT_POS_Y(128), .COLS(32), .ROWS(8), .SCALE(2), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .in(vin), .out(vout),
        .char_addr(char_addr), .char_code(char_code),
        .font_addr(font_addr), .font_pixels(font_pixels),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .opaque(opaque), .blink_en(blink_en),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        char_code   <= char_ram[char_addr];
        font_pixels <= font_rom[font_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                         input logic [11:0] rgb);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[0];
        vin.vsync  = v[0];
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
    endtask

    task automatic idle();
        drive(11'h7ff, 11'h000, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic [11:0] rgb, input logic [11:0] exp);
        drive(h, v, hb, 1'b0, rgb);
        @(posedge clk);
        #1 idle();
        repeat (2) @(posedge clk);
        #1 check({tag, "_early"}, 32'(vout.hcount), 32'h7ff);
        @(posedge clk);
        #1;
        check({tag, "_tim"}, 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
              32'({h, v, h[0], v[0], hb, 1'b0}));
        check({tag, "_rgb"}, 32'(vout.rgb), 32'(exp));
    endtask

    task automatic frame_end();
        drive(11'h7ff, 11'h7ff, 1'b1, 1'b1, 12'h000);
        repeat (2) @(posedge clk);
        #1 idle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tim"}, 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 0);
        check({tag, "_rgb"}, 32'(vout.rgb), 0);
        check({tag, "_caddr"}, 32'(char_addr), 0);
        check({tag, "_faddr"}, 32'(font_addr), 0);
        check({tag, "_phase"}, 32'(dut.u_blink.phase_q), 1);
        check({tag, "_fcnt"}, 32'(dut.u_blink.frame_cnt_q), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) char_ram[i] = 8'h20;
        for (int i = 0; i < 2048; i++) font_rom[i] = 8'h00;
        char_ram[0]   = 8'h41;
        char_ram[34]  = 8'h41;
        char_ram[35]  = 8'h41;
        char_ram[101] = 8'h41;
        font_rom[11'h410] = 8'h80;
        fg_rgb = 12'h0f0;
        bg_rgb = 12'h00f;
        opaque = 1'b0;
        blink_en = 1'b0;
        cursor_en = 1'b0;
        cursor_col = 5'd2;
        cursor_row = 3'd1;
        drive(11'd128, 11'd128, 1'b0, 1'b0, 12'hfff);
        repeat (3) @(posedge clk);
        #1 check_reset_state("rst0");
        rst = 1'b0;
        idle();
        repeat (4) @(posedge clk);
        #1;
        probe("glyph_tl", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        probe("glyph_br", 11'd131, 11'd131, 1'b0, 12'h888, 12'h0f0);
        probe("pass_x132", 11'd132, 11'd128, 1'b0, 12'h888, 12'h888);
        probe("pass_y132", 11'd128, 11'd132, 1'b0, 12'h888, 12'h888);
        probe("blank", 11'd128, 11'd128, 1'b1, 12'h888, 12'h000);
        probe("left_out", 11'd127, 11'd128, 1'b0, 12'h123, 12'h123);
        opaque = 1'b1;
        probe("opq_bg", 11'd132, 11'd128, 1'b0, 12'h888, 12'h00f);
        probe("opq_fg", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        probe("opq_last", 11'd1151, 11'd639, 1'b0, 12'h888, 12'h00f);
        probe("opq_right", 11'd1152, 11'd128, 1'b0, 12'h456, 12'h456);
        probe("opq_left", 11'd127, 11'd200, 1'b0, 12'h789, 12'h789);
        probe("opq_below", 11'd300, 11'd640, 1'b0, 12'habc, 12'habc);
        drive(11'd288, 11'd320, 1'b0, 1'b0, 12'h888);
        @(posedge clk);
        #1 check("char_addr", 32'(char_addr), 101);
        idle();
        @(posedge clk);
        #1 check("font_addr", 32'(font_addr), 32'h410);
        repeat (2) @(posedge clk);
        #1 check("addr_rgb", 32'(vout.rgb), 32'h0f0);
        cursor_en = 1'b1;
        probe("cur_glyph", 11'd192, 11'd192, 1'b0, 12'h888, 12'h00f);
        probe("cur_fill", 11'd196, 11'd192, 1'b0, 12'h888, 12'h0f0);
        probe("next_glyph", 11'd224, 11'd192, 1'b0, 12'h888, 12'h0f0);
        probe("next_fill", 11'd228, 11'd192, 1'b0, 12'h888, 12'h00f);
        opaque = 1'b0;
        probe("cur_fill_tr", 11'd196, 11'd192, 1'b0, 12'h888, 12'h0f0);
        opaque = 1'b1;
        blink_en = 1'b1;
        probe("blink_f0", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        frame_end();
        check("fcnt_f1", 32'(dut.u_blink.frame_cnt_q), 1);
        probe("blink_f1", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        frame_end();
        check("phase_f2", 32'(dut.u_blink.phase_q), 0);
        probe("blink_f2", 11'd128, 11'd128, 1'b0, 12'h888, 12'h00f);
        probe("blink_cur_g", 11'd192, 11'd192, 1'b0, 12'h888, 12'h00f);
        probe("blink_cur_f", 11'd196, 11'd192, 1'b0, 12'h888, 12'h00f);
        blink_en = 1'b0;
        probe("noblink_f2", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        blink_en = 1'b1;
        frame_end();
        probe("blink_f3", 11'd128, 11'd128, 1'b0, 12'h888, 12'h00f);
        frame_end();
        probe("blink_f4", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        frame_end();
        frame_end();
        probe("blink_f6", 11'd128, 11'd128, 1'b0, 12'h888, 12'h00f);
        drive(11'd128, 11'd128, 1'b0, 1'b0, 12'h888);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(11'h7ff, 11'h7ff, 1'b1, 1'b1, 12'h000);
        repeat (2) @(posedge clk);
        #1 idle();
        @(posedge clk);
        #1 check_reset_state("rst1");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        probe("post_rst_fg", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        probe("post_rst_bg", 11'd132, 11'd128, 1'b0, 12'h888, 12'h00f);
        frame_end();
        probe("post_rst_f1", 11'd128, 11'd128, 1'b0, 12'h888, 12'h0f0);
        frame_end();
        probe("post_rst_f2", 11'd128, 11'd128, 1'b0, 12'h888, 12'h00f);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
